// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the single-cycle MIPS core.
//
// Drives the core's `enable` (PC advance + register-file commit) and
// sequences free-run, single-step and halt. Execution stops on a host stop
// request, a PC breakpoint, a halt instruction word or a cycle limit. The
// offending instruction is never executed, because `enable` drops in the
// same cycle the condition is seen.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-low
//   start       begin free-run from IDLE/HALT
//   stop        request halt while running
//   step        execute exactly one instruction from IDLE/HALT
//   bp_en       breakpoint enable
//   bp_addr     breakpoint PC
//   pc          current PC from the program counter
//   instr       instruction at pc
//   max_cycles  run limit, 0 = unlimited
//   enable      combinational: advance PC / commit this cycle
//   busy        registered: state is RUN or STEP
//   halted      registered: state is HALT
//   halt_cause  registered: 0 none, 1 stop, 2 breakpoint, 3 halt word, 4 limit
//   cycle_cnt   registered: enabled cycles since the last start/step
module cpu_run_ctrl #(
  parameter int          PC_W      = 6,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic [31:0]      instr,
  input  logic [CNT_W-1:0] max_cycles,
  output logic             enable,
  output logic             busy,
  output logic             halted,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_STOP  = 3'd1;
  localparam logic [2:0] CAUSE_BP    = 3'd2;
  localparam logic [2:0] CAUSE_WORD  = 3'd3;
  localparam logic [2:0] CAUSE_LIMIT = 3'd4;

  state_t           state;
  // Set on entry to RUN so that resuming from the breakpoint PC executes
  // that instruction instead of re-tripping immediately.
  logic             first;

  logic             hit_stop, hit_word, hit_bp, hit_lim, run_halt;
  logic [2:0]       run_cause;
  logic [CNT_W-1:0] cnt_next;

  // Halt conditions, evaluated in the cycle they apply to.
  always_comb begin
    hit_stop = stop;
    hit_word = (instr == HALT_WORD);
    hit_bp   = bp_en && (pc == bp_addr) && !first;
    hit_lim  = (max_cycles != '0) && (cycle_cnt == max_cycles);
    run_halt = hit_stop || hit_word || hit_bp || hit_lim;

    // Priority: stop > halt word > breakpoint > limit.
    run_cause = CAUSE_NONE;
    if (hit_stop)      run_cause = CAUSE_STOP;
    else if (hit_word) run_cause = CAUSE_WORD;
    else if (hit_bp)   run_cause = CAUSE_BP;
    else if (hit_lim)  run_cause = CAUSE_LIMIT;
  end

  // Saturating increment: the counter sticks at all-ones.
  always_comb begin
    cnt_next = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
  end

  // enable is held low while reset is asserted, whatever the state.
  always_comb begin
    enable = 1'b0;
    if (reset) begin
      unique case (state)
        S_RUN:   enable = !run_halt;
        S_STEP:  enable = !hit_word;
        default: enable = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      first      <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      halt_cause <= CAUSE_NONE;
      cycle_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_HALT: begin
          // start beats step; stop has no effect here.
          if (start) begin
            state      <= S_RUN;
            first      <= 1'b1;
            busy       <= 1'b1;
            halted     <= 1'b0;
            halt_cause <= CAUSE_NONE;
            cycle_cnt  <= '0;
          end else if (step) begin
            state      <= S_STEP;
            first      <= 1'b0;
            busy       <= 1'b1;
            halted     <= 1'b0;
            halt_cause <= CAUSE_NONE;
            cycle_cnt  <= '0;
          end
        end

        S_RUN: begin
          first <= 1'b0;
          if (run_halt) begin
            state      <= S_HALT;
            busy       <= 1'b0;
            halted     <= 1'b1;
            halt_cause <= run_cause;
          end else begin
            cycle_cnt <= cnt_next;
          end
        end

        S_STEP: begin
          // Only the halt word can stop a step; stop/bp/limit are ignored.
          busy <= 1'b0;
          if (hit_word) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            halt_cause <= CAUSE_WORD;
          end else begin
            state     <= S_IDLE;
            cycle_cnt <= cnt_next;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the single-cycle MIPS core. It owns the `enable` input of the program counter and register-file write path. It sequences execution as free-run, single-step and halt, and stops the core on:
- a host stop request
- a PC breakpoint
- a halt instruction word
- a cycle limit

It sits between the host/debug interface and the core top level, and observes the fetched PC and instruction.

## Interface
Parameters:
- `PC_W`, 6, PC width (matches program counter `q`)
- `CNT_W`, 16, cycle counter width
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding treated as halt

Ports:
- `clk` in 1, single clock, rising edge
- `reset` in 1, synchronous, active-low (sampled only at `clk` rising edge)
- `start` in 1, begin free-run (level sampled per cycle)
- `stop` in 1, request halt
- `step` in 1, execute exactly one instruction
- `bp_en` in 1, breakpoint enable
- `bp_addr` in PC_W, breakpoint PC
- `pc` in PC_W, current PC from program counter
- `instr` in 32, instruction at `pc` from instruction memory
- `max_cycles` in CNT_W, run limit; 0 = unlimited
- `enable` out 1, advance PC / commit register write this cycle
- `busy` out 1, state is RUN or STEP
- `halted` out 1, state is HALT
- `halt_cause` out 3: 0 none, 1 stop, 2 breakpoint, 3 halt word, 4 cycle limit
- `cycle_cnt` out CNT_W, enabled cycles since last `start`/`step` from IDLE/HALT

## Operation
- States: IDLE, RUN, STEP, HALT.
- IDLE:
  - `start` → RUN, clears `cycle_cnt` and `halt_cause`, sets `first` flag.
  - Otherwise `step` → STEP, clears `cycle_cnt` and `halt_cause`.
  - `start` beats `step` when both are high.
- RUN: halt checks are evaluated combinationally in the same cycle, with priority stop > halt word > breakpoint > limit.
  - `stop` → HALT, cause 1.
  - `instr == HALT_WORD` → HALT, cause 3.
  - `bp_en && pc == bp_addr && !first` → HALT, cause 2.
  - `max_cycles != 0 && cycle_cnt == max_cycles` → HALT, cause 4.
  - When any halt is hit, `enable` = 0 that cycle: the offending instruction is not executed.
  - Otherwise `enable` = 1, `cycle_cnt` increments, stay in RUN.
  - `first` clears after the first RUN cycle, so resuming from a breakpoint PC does not re-trip the breakpoint.
  - `start` and `step` are ignored in RUN.
- STEP: lasts exactly one cycle.
  - `instr == HALT_WORD` → `enable` = 0, go to HALT, cause 3.
  - Otherwise `enable` = 1, `cycle_cnt` +1, go to IDLE.
  - Breakpoint, limit and `stop` are ignored in STEP.
- HALT:
  - `enable` = 0, `halt_cause` held.
  - `start` → RUN (clears count and cause, sets `first`).
  - Else `step` → STEP.
  - `stop` has no effect.
- `cycle_cnt` saturates at all-ones and never wraps.
- `enable` is combinational from state plus `stop`/`instr`/`pc`/`bp_*`/`cycle_cnt`/`max_cycles`. It is forced to 0 whenever `reset` is low.
- This block does not reset the PC. Core reset remains separate.

## Timing
- Reset (`reset` = 0 at an edge):
  - Registers: state IDLE, `cycle_cnt` 0, `halt_cause` 0, `first` 0.
  - Outputs: `busy` 0, `halted` 0, `enable` 0.
  - Reset wins over every other input, including mid-RUN.
- `start` sampled at edge N moves the state to RUN at N; the first `enable` = 1 is in cycle N+1.
- A halt condition present in cycle K (RUN):
  - `enable` = 0 in cycle K.
  - `halted` = 1 and `halt_cause` valid from edge K onward.
- `max_cycles` = M (nonzero): exactly M `enable` pulses, then HALT with cause 4. `cycle_cnt` = M at halt.
- `step`: exactly one `enable` pulse, `busy` high for one cycle.
- `halt_cause`, `halted`, `busy` and `cycle_cnt` are registered outputs.

## Test plan
- Reset mid-RUN (`cycle_cnt` = 5) → next cycle IDLE, `cycle_cnt` = 0, `enable` = 0, `halt_cause` = 0.
- `start` with `max_cycles` = 4, no halts → 4 consecutive `enable` pulses, then `halted` = 1, `halt_cause` = 4, `cycle_cnt` = 4.
- `bp_en` = 1, `bp_addr` = 6'd3, PC increments from 0 → `enable` high at PC 0–2, low at PC 3, cause 2, `cycle_cnt` = 3. Then `start` → runs past PC 3 without re-halting.
- `instr` = 32'hFFFF_FFFF at PC 2 during RUN → `enable` = 0 at PC 2, cause 3. `step` from HALT → HALT again with zero `enable` pulses.
- `stop` and a breakpoint hit in the same cycle → cause 1. `start`+`step` together in IDLE → RUN.
- Three `step` pulses from IDLE → three single `enable` pulses, `busy` high one cycle each, ends IDLE, `cycle_cnt` = 1 after each.
